// File: rtl/mpc_types.sv
// Shared types and sizing constants for the return crossbar entry manager.
package mpc_types;

   localparam int RTN_ENTRY_NUM = 8;
   localparam int RTN_CH_NUM    = 3;
   localparam int RTN_CH_ID_W   = 2;
   localparam int RTN_PTR_W     = 3;

   typedef logic [RTN_CH_ID_W-1:0] rtn_ch_id_t;

   localparam rtn_ch_id_t RTN_CH_ILLEGAL = 2'd3;

   // Lowest free entry; returns 0 when every entry is taken.
   function automatic logic [RTN_PTR_W-1:0] rtn_first_free(input logic [RTN_ENTRY_NUM-1:0] v);
      rtn_first_free = '0;
      for (int i = RTN_ENTRY_NUM - 1; i >= 0; i--) begin
         if (!v[i]) rtn_first_free = RTN_PTR_W'(i);
      end
   endfunction

endpackage

// File: rtl/rtn_xbar_entry_ctrl_if.sv
// Bank-side and channel-side handshake bundle of one return buffer bank.
interface rtn_xbar_entry_ctrl_if;
   import mpc_types::*;

   logic                 d_bank_rsp_valid;
   logic                 d_bank_rsp_ready;
   rtn_ch_id_t           d_bank_rsp_channel_id;
   logic [RTN_PTR_W-1:0] bank_w_ptr;

   logic u_ch_0_rsp_valid;
   logic u_ch_1_rsp_valid;
   logic u_ch_2_rsp_valid;
   logic u_ch_0_rsp_ready;
   logic u_ch_1_rsp_ready;
   logic u_ch_2_rsp_ready;

   logic [RTN_ENTRY_NUM-1:0] ch_0_r_entry_1hot_id;
   logic [RTN_ENTRY_NUM-1:0] ch_1_r_entry_1hot_id;
   logic [RTN_ENTRY_NUM-1:0] ch_2_r_entry_1hot_id;

   modport master (
      output d_bank_rsp_valid, d_bank_rsp_channel_id,
      output u_ch_0_rsp_ready, u_ch_1_rsp_ready, u_ch_2_rsp_ready,
      input  d_bank_rsp_ready, bank_w_ptr,
      input  u_ch_0_rsp_valid, u_ch_1_rsp_valid, u_ch_2_rsp_valid,
      input  ch_0_r_entry_1hot_id, ch_1_r_entry_1hot_id, ch_2_r_entry_1hot_id
   );

   modport slave (
      input  d_bank_rsp_valid, d_bank_rsp_channel_id,
      input  u_ch_0_rsp_ready, u_ch_1_rsp_ready, u_ch_2_rsp_ready,
      output d_bank_rsp_ready, bank_w_ptr,
      output u_ch_0_rsp_valid, u_ch_1_rsp_valid, u_ch_2_rsp_valid,
      output ch_0_r_entry_1hot_id, ch_1_r_entry_1hot_id, ch_2_r_entry_1hot_id
   );

endinterface

// File: rtl/ns_gnrl_dfflr.sv
// Generic load-enabled flop bank with asynchronous active-low clear to zero.
module ns_gnrl_dfflr #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout <= '0;
      end else if (lden) begin
         qout <= dnxt;
      end
   end

endmodule

// File: rtl/rtn_xbar_entry_ctrl_oldest_sel.sv
// Picks the oldest candidate entry: a candidate survives only if no other candidate is older.
module rtn_oldest_sel #(
   parameter int NUM_ENTRY = 8
) (
   input  logic [NUM_ENTRY-1:0]                cand,
   input  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] older,
   output logic [NUM_ENTRY-1:0]                oldest
);

   logic [NUM_ENTRY-1:0] blocked;

   always_comb begin
      blocked = '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
         for (int j = 0; j < NUM_ENTRY; j++) begin
            blocked[i] = blocked[i] | (cand[j] & older[j][i]);
         end
      end
   end

   assign oldest = cand & ~blocked;

endmodule

// File: rtl/rtn_xbar_entry_ctrl.sv
// Per-bank entry manager: allocates return buffer entries and hands each channel its oldest one.
module rtn_xbar_entry_ctrl
   import mpc_types::*;
#(
   parameter int NUM_ENTRY = RTN_ENTRY_NUM,
   parameter int NUM_CH    = RTN_CH_NUM
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rtn_xbar_entry_ctrl_if.slave bus,
   output logic                 illegal_ch_err
);

   logic [NUM_ENTRY-1:0]                  valid_q;
   logic [NUM_ENTRY-1:0]                  valid_d;
   logic                                  valid_ld;
   logic [NUM_ENTRY-1:0][RTN_CH_ID_W-1:0] tag_q;
   logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0]   older_q;
   logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0]   older_d;

   logic [RTN_PTR_W-1:0] w_ptr;
   logic [NUM_ENTRY-1:0] w_onehot;
   logic                 bank_hs;
   logic                 ch_legal;
   logic                 write_en;
   logic                 illegal_d;
   logic [NUM_ENTRY-1:0] free_mask;

   logic [NUM_CH-1:0]                 ch_ready;
   logic [NUM_CH-1:0]                 ch_valid;
   logic [NUM_CH-1:0][NUM_ENTRY-1:0]  ch_cand;
   logic [NUM_CH-1:0][NUM_ENTRY-1:0]  ch_oldest;

   // Ready and write pointer look only at registered state, so a free never feeds ready combinationally.
   assign bus.d_bank_rsp_ready = ~&valid_q;
   assign w_ptr                = rtn_first_free(valid_q);
   assign bus.bank_w_ptr       = w_ptr;
   assign w_onehot             = NUM_ENTRY'(1) << w_ptr;

   assign bank_hs   = bus.d_bank_rsp_valid & bus.d_bank_rsp_ready;
   assign ch_legal  = (bus.d_bank_rsp_channel_id != RTN_CH_ILLEGAL);
   assign write_en  = bank_hs & ch_legal;
   assign illegal_d = bank_hs & ~ch_legal;

   assign ch_ready = {bus.u_ch_2_rsp_ready, bus.u_ch_1_rsp_ready, bus.u_ch_0_rsp_ready};

   always_comb begin
      free_mask = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_valid[c] && ch_ready[c]) free_mask = free_mask | ch_oldest[c];
      end
   end

   // The write target is always invalid now, so it can never coincide with a freed entry.
   assign valid_d  = (valid_q & ~free_mask) | (write_en ? w_onehot : '0);
   assign valid_ld = write_en | (|free_mask);

   // New entry is younger than every currently valid entry and older than nothing.
   always_comb begin
      older_d = older_q;
      if (write_en) begin
         for (int i = 0; i < NUM_ENTRY; i++) begin
            older_d[w_ptr][i] = 1'b0;
            if (i != int'(w_ptr)) older_d[i][w_ptr] = valid_q[i];
         end
      end
   end

   ns_gnrl_dfflr #(.DW(NUM_ENTRY)) u_valid_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (valid_ld),
      .dnxt  (valid_d),
      .qout  (valid_q)
   );

   ns_gnrl_dfflr #(.DW(NUM_ENTRY * NUM_ENTRY)) u_older_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (write_en),
      .dnxt  (older_d),
      .qout  (older_q)
   );

   ns_gnrl_dfflr #(.DW(1)) u_err_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (1'b1),
      .dnxt  (illegal_d),
      .qout  (illegal_ch_err)
   );

   for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_tag
      ns_gnrl_dfflr #(.DW(RTN_CH_ID_W)) u_tag_dff (
         .clk   (clk),
         .rst_n (rst_n),
         .lden  (write_en & w_onehot[e]),
         .dnxt  (bus.d_bank_rsp_channel_id),
         .qout  (tag_q[e])
      );
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_cand
         assign ch_cand[c][e] = valid_q[e] & (tag_q[e] == RTN_CH_ID_W'(c));
      end

      rtn_oldest_sel #(.NUM_ENTRY(NUM_ENTRY)) u_oldest_sel (
         .cand   (ch_cand[c]),
         .older  (older_q),
         .oldest (ch_oldest[c])
      );

      assign ch_valid[c] = |ch_oldest[c];
   end

   assign bus.u_ch_0_rsp_valid     = ch_valid[0];
   assign bus.u_ch_1_rsp_valid     = ch_valid[1];
   assign bus.u_ch_2_rsp_valid     = ch_valid[2];
   assign bus.ch_0_r_entry_1hot_id = ch_oldest[0];
   assign bus.ch_1_r_entry_1hot_id = ch_oldest[1];
   assign bus.ch_2_r_entry_1hot_id = ch_oldest[2];

endmodule

// File: tb/tb_rtn_xbar_entry_ctrl.sv
// Scoreboard bench for the return crossbar entry manager: stimulus queues expectations, a monitor checks them.
module tb_rtn_xbar_entry_ctrl;

   logic clk;
   logic rst_n;
   logic illegal_ch_err;

   rtn_xbar_entry_ctrl_if bus ();

   rtn_xbar_entry_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .illegal_ch_err (illegal_ch_err)
   );

   int checks   = 0;
   int failures = 0;
   int errPulses = 0;

   logic [2:0] wptrQ[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared comparison point; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic popCompare(input int ch, input logic [7:0] act);
      logic [7:0] exp;
      int sz;
      sz = (ch == 0) ? q0.size() : (ch == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL ch%0d_unexpected_pop: got id %0h with no entry expected", ch, act);
      end else begin
         case (ch)
            0:       exp = q0.pop_front();
            1:       exp = q1.pop_front();
            default: exp = q2.pop_front();
         endcase
         checkOutput($sformatf("ch%0d_pop_id", ch), 32'(act), 32'(exp));
      end
   endtask

   // Monitor: compares at the falling edge whenever a handshake is presented.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.d_bank_rsp_valid && bus.d_bank_rsp_ready) begin
            if (wptrQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL bank_w_ptr_unexpected: got %0d with no write expected", bus.bank_w_ptr);
            end else begin
               checkOutput("bank_w_ptr", 32'(bus.bank_w_ptr), 32'(wptrQ.pop_front()));
            end
         end
         if (bus.u_ch_0_rsp_valid && bus.u_ch_0_rsp_ready) popCompare(0, bus.ch_0_r_entry_1hot_id);
         if (bus.u_ch_1_rsp_valid && bus.u_ch_1_rsp_ready) popCompare(1, bus.ch_1_r_entry_1hot_id);
         if (bus.u_ch_2_rsp_valid && bus.u_ch_2_rsp_ready) popCompare(2, bus.ch_2_r_entry_1hot_id);
         if (illegal_ch_err) errPulses++;
      end
   end

   // Drives one cycle of bank and channel traffic starting just after a rising edge.
   task automatic applyStimulus(input logic bv, input logic [1:0] ch, input logic [2:0] expPtr,
                                input logic [2:0] rdy);
      if (bv) begin
         wptrQ.push_back(expPtr);
         case (ch)
            2'd0:    q0.push_back(8'(1) << expPtr);
            2'd1:    q1.push_back(8'(1) << expPtr);
            2'd2:    q2.push_back(8'(1) << expPtr);
            default: ;
         endcase
      end
      bus.d_bank_rsp_valid      = bv;
      bus.d_bank_rsp_channel_id = ch;
      bus.u_ch_0_rsp_ready      = rdy[0];
      bus.u_ch_1_rsp_ready      = rdy[1];
      bus.u_ch_2_rsp_ready      = rdy[2];
      @(posedge clk);
      #1;
      bus.d_bank_rsp_valid      = 1'b0;
      bus.d_bank_rsp_channel_id = 2'd0;
      bus.u_ch_0_rsp_ready      = 1'b0;
      bus.u_ch_1_rsp_ready      = 1'b0;
      bus.u_ch_2_rsp_ready      = 1'b0;
   endtask

   task automatic drainAll(input string name);
      int n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 30) begin
         applyStimulus(1'b0, 2'd0, 3'd0, 3'b111);
         n++;
      end
      checkOutput({name, "_left_pending"}, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_ready"}, 32'(bus.d_bank_rsp_ready), 32'd1);
      checkOutput({name, "_wptr"}, 32'(bus.bank_w_ptr), 32'd0);
      checkOutput({name, "_valids"},
                  32'({bus.u_ch_2_rsp_valid, bus.u_ch_1_rsp_valid, bus.u_ch_0_rsp_valid}), 32'd0);
      checkOutput({name, "_ids"},
                  {8'd0, bus.ch_2_r_entry_1hot_id, bus.ch_1_r_entry_1hot_id, bus.ch_0_r_entry_1hot_id},
                  32'd0);
      checkOutput({name, "_err"}, 32'(illegal_ch_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      bus.d_bank_rsp_valid      = 1'b0;
      bus.d_bank_rsp_channel_id = 2'd0;
      bus.u_ch_0_rsp_ready      = 1'b0;
      bus.u_ch_1_rsp_ready      = 1'b0;
      bus.u_ch_2_rsp_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkIdle("reset");

      // Three ch1 responses back to back, then ch1 drains them in order.
      applyStimulus(1'b1, 2'd1, 3'd0, 3'b000);
      checkOutput("ch1_first_valid", 32'(bus.u_ch_1_rsp_valid), 32'd1);
      checkOutput("ch1_first_id", 32'(bus.ch_1_r_entry_1hot_id), 32'h01);
      applyStimulus(1'b1, 2'd1, 3'd1, 3'b000);
      applyStimulus(1'b1, 2'd1, 3'd2, 3'b000);
      drainAll("ch1_seq");
      checkIdle("ch1_seq_idle");

      // Fill the bank with channels 0,1,2,0,1,2,0,1.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'(i % 3), 3'(i), 3'b000);
      checkOutput("full_ready", 32'(bus.d_bank_rsp_ready), 32'd0);
      checkOutput("full_ch0_id", 32'(bus.ch_0_r_entry_1hot_id), 32'h01);
      checkOutput("full_ch1_id", 32'(bus.ch_1_r_entry_1hot_id), 32'h02);
      checkOutput("full_ch2_id", 32'(bus.ch_2_r_entry_1hot_id), 32'h04);

      // ch2 frees entry 2; the hole is reused for ch0, which must come out last for ch0.
      applyStimulus(1'b0, 2'd0, 3'd0, 3'b100);
      checkOutput("hole_ready", 32'(bus.d_bank_rsp_ready), 32'd1);
      checkOutput("hole_wptr", 32'(bus.bank_w_ptr), 32'd2);
      applyStimulus(1'b1, 2'd0, 3'd2, 3'b000);
      checkOutput("refull_ready", 32'(bus.d_bank_rsp_ready), 32'd0);
      drainAll("full");
      checkIdle("full_idle");

      // Hole reuse: ch0 in entries 0,1, pop 0, refill 0 -> entry 1 before entry 0.
      applyStimulus(1'b1, 2'd0, 3'd0, 3'b000);
      applyStimulus(1'b1, 2'd0, 3'd1, 3'b000);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'b001);
      applyStimulus(1'b1, 2'd0, 3'd0, 3'b000);
      checkOutput("reuse_ch0_head", 32'(bus.ch_0_r_entry_1hot_id), 32'h02);
      drainAll("reuse");

      // One entry per channel, then all three pop while a new ch1 entry is written.
      applyStimulus(1'b1, 2'd0, 3'd0, 3'b000);
      applyStimulus(1'b1, 2'd1, 3'd1, 3'b000);
      applyStimulus(1'b1, 2'd2, 3'd2, 3'b000);
      applyStimulus(1'b1, 2'd1, 3'd3, 3'b111);
      checkOutput("simul_valids",
                  32'({bus.u_ch_2_rsp_valid, bus.u_ch_1_rsp_valid, bus.u_ch_0_rsp_valid}), 32'b010);
      checkOutput("simul_ch1_id", 32'(bus.ch_1_r_entry_1hot_id), 32'h08);
      checkOutput("simul_wptr", 32'(bus.bank_w_ptr), 32'd0);
      drainAll("simul");
      checkIdle("simul_idle");

      // Illegal channel id: pointer still driven, no entry, single error pulse.
      applyStimulus(1'b1, 2'd3, 3'd0, 3'b000);
      checkOutput("illegal_err_pulse", 32'(illegal_ch_err), 32'd1);
      checkOutput("illegal_no_valid",
                  32'({bus.u_ch_2_rsp_valid, bus.u_ch_1_rsp_valid, bus.u_ch_0_rsp_valid}), 32'd0);
      applyStimulus(1'b0, 2'd0, 3'd0, 3'b000);
      checkIdle("illegal_after");

      // Asynchronous reset in the middle of traffic discards pending entries at once.
      applyStimulus(1'b1, 2'd0, 3'd0, 3'b000);
      applyStimulus(1'b1, 2'd2, 3'd1, 3'b000);
      checkOutput("pre_reset_ch2_valid", 32'(bus.u_ch_2_rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkIdle("mid_reset");
      q0.delete();
      q1.delete();
      q2.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkIdle("post_reset");
      applyStimulus(1'b1, 2'd2, 3'd0, 3'b000);
      checkOutput("post_reset_ch2_id", 32'(bus.ch_2_r_entry_1hot_id), 32'h01);
      drainAll("post_reset");

      checkOutput("err_pulse_count", 32'(errPulses), 32'd1);
      checkOutput("wptr_left_pending", 32'(wptrQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
